// File: rtl/instr_mem_fetch.sv
// Synchronous instruction memory with a run-time programming port and a
// valid/ready fetch interface that returns one registered word per accept.
module instr_mem_fetch #(
    parameter int          DEPTH_LOG2 = 8,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic                  rsp_err,
    input  logic                  flush,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [31:0]           prog_data
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH-1:0]      r_written;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_instr;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_idx          = req_addr[DEPTH_LOG2+1:2];
    assign w_misaligned   = |req_addr[1:0];
    assign w_out_of_range = |req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

    // A slot frees up either when empty or when the held word drains this cycle.
    assign req_ready = !rst && !flush && (!r_rsp_valid || rsp_ready);
    assign w_accept  = req_valid && req_ready;

    // NOTE: the array has no reset; validity is tracked by r_written instead,
    // which keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (prog_we && !rst) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_written <= '0;
        end else if (prog_we) begin
            r_written[prog_addr] <= 1'b1;
        end
    end

    // NOTE: non-blocking reads of r_mem/r_written give read-first behaviour
    // when a write and an accept hit the same word on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= NOP_INSTR;
            r_rsp_err   <= 1'b0;
        end else if (flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            if (w_misaligned || w_out_of_range) begin
                r_rsp_instr <= NOP_INSTR;
                r_rsp_err   <= 1'b1;
            end else if (!r_written[w_idx]) begin
                r_rsp_instr <= NOP_INSTR;
                r_rsp_err   <= 1'b0;
            end else begin
                r_rsp_instr <= r_mem[w_idx];
                r_rsp_err   <= 1'b0;
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_instr = r_rsp_instr;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: directed scenarios followed by random traffic,
// all checked against an array-based reference of the fetch rules.
module tb_instr_mem_fetch;

    localparam int          DEPTH_LOG2 = 8;
    localparam int          DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem     [DEPTH];
    bit          m_written [DEPTH];
    bit          m_v;
    logic [31:0] m_instr;
    bit          m_err;

    logic [31:0] prog_words [8] = '{32'h01200093, 32'hfc800113, 32'h021101b3, 32'h02111233,
                                     32'h021142b3, 32'h02116333, 32'h021153b3, 32'h02117433};

    instr_mem_fetch #(.DEPTH_LOG2(DEPTH_LOG2), .ADDR_WIDTH(32), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: response for a fetch, derived from the byte address by arithmetic.
    task automatic expected_rsp(input logic [31:0] addr, output logic [31:0] instr, output bit err);
        longint unsigned a = longint'(addr);
        if ((a % 4) != 0 || a >= 4 * DEPTH) begin
            instr = NOP;
            err   = 1'b1;
        end else if (!m_written[a / 4]) begin
            instr = NOP;
            err   = 1'b0;
        end else begin
            instr = m_mem[a / 4];
            err   = 1'b0;
        end
    endtask

    // One clock with the currently driven inputs; checks req_ready before the
    // edge and the registered response after it.
    task automatic do_cycle(input string tag);
        bit          exp_ready;
        logic [31:0] ni;
        bit          ne;
        #1;
        exp_ready = !rst && !flush && (!m_v || rsp_ready);
        chk({tag, ".req_ready"}, {31'b0, req_ready}, {31'b0, exp_ready});
        if (rst) begin
            m_v     = 1'b0;
            m_instr = NOP;
            m_err   = 1'b0;
            foreach (m_written[i]) m_written[i] = 1'b0;
        end else begin
            if (flush) begin
                m_v = 1'b0;
            end else if (req_valid && exp_ready) begin
                expected_rsp(req_addr, ni, ne);
                m_v     = 1'b1;
                m_instr = ni;
                m_err   = ne;
            end else if (m_v && rsp_ready) begin
                m_v = 1'b0;
            end
            if (prog_we) begin
                m_mem[prog_addr]     = prog_data;
                m_written[prog_addr] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".rsp_valid"}, {31'b0, rsp_valid}, {31'b0, m_v});
        chk({tag, ".rsp_instr"}, rsp_instr, m_instr);
        chk({tag, ".rsp_err"}, {31'b0, rsp_err}, {31'b0, m_err});
    endtask

    task automatic idle();
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr);
        idle();
        req_valid = 1'b1;
        req_addr  = addr;
        do_cycle(tag);
    endtask

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_v     = 1'b0;
        m_instr = NOP;
        m_err   = 1'b0;

        idle();
        rst = 1'b1;
        do_cycle("reset0");
        do_cycle("reset1");
        chk("reset.valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset.instr", rsp_instr, NOP);

        fetch("unwritten0", 32'h0);
        chk("unwritten0.plan", rsp_instr, NOP);
        idle();
        do_cycle("drain0");

        for (int i = 0; i < 8; i++) begin
            idle();
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = prog_words[i];
            do_cycle("prog");
        end

        for (int i = 0; i < 8; i++) begin
            fetch("b2b", 32'(4 * i));
            chk("b2b.plan", rsp_instr, prog_words[i]);
        end
        idle();
        do_cycle("drain1");

        fetch("misalign", 32'h6);
        chk("misalign.err", {31'b0, rsp_err}, 32'd1);
        fetch("oor", 32'h400);
        chk("oor.err", {31'b0, rsp_err}, 32'd1);
        idle();
        do_cycle("drain2");

        fetch("bp.accept", 32'h8);
        for (int i = 0; i < 3; i++) begin
            idle();
            req_valid = 1'b1;
            req_addr  = 32'hC;
            rsp_ready = 1'b0;
            do_cycle("bp.hold");
            chk("bp.hold.plan", rsp_instr, 32'h021101b3);
        end
        fetch("bp.release", 32'hC);
        chk("bp.release.plan", rsp_instr, 32'h02111233);

        idle();
        req_valid = 1'b1;
        req_addr  = 32'h8;
        prog_we   = 1'b1;
        prog_addr = 8'd2;
        prog_data = 32'hDEADBEEF;
        do_cycle("collide");
        chk("collide.plan", rsp_instr, 32'h021101b3);
        fetch("collide.refetch", 32'h8);
        chk("collide.refetch.plan", rsp_instr, 32'hDEADBEEF);

        fetch("flush.load", 32'h0);
        idle();
        req_valid = 1'b1;
        req_addr  = 32'h4;
        rsp_ready = 1'b0;
        flush     = 1'b1;
        do_cycle("flush");
        chk("flush.plan", {31'b0, rsp_valid}, 32'd0);

        fetch("pre_rst", 32'h10);
        idle();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        prog_we   = 1'b1;
        prog_addr = 8'd1;
        prog_data = 32'h12345678;
        do_cycle("mid_rst");
        fetch("post_rst", 32'h4);
        chk("post_rst.plan", rsp_instr, NOP);

        for (int n = 0; n < 400; n++) begin
            idle();
            rst       = ($urandom_range(49) == 0);
            flush     = ($urandom_range(9) == 0);
            req_valid = ($urandom_range(3) != 0);
            rsp_ready = ($urandom_range(3) != 0);
            prog_we   = ($urandom_range(2) == 0);
            prog_addr = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15));
            prog_data = $urandom;
            case ($urandom_range(7))
                6:       req_addr = (32'($urandom_range(63)) << 2) | 32'($urandom_range(3, 1));
                7:       req_addr = $urandom | 32'h0000_0400;
                5:       req_addr = 32'($urandom_range(DEPTH - 1)) << 2;
                default: req_addr = 32'($urandom_range(15)) << 2;
            endcase
            do_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
